// File: rtl/bit_capture_pkg.sv
// Shared types for the bit capture register: capture modes and handshake states.
package bit_capture_pkg;

  typedef enum logic [1:0] {
    MODE_BIT   = 2'b00,
    MODE_ALL   = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/bit_capture_reg.sv
// Assembles a word from per-bit, whole-word or serial captures, tracks written bits,
// and hands the completed word out on a valid/ready handshake.
module bit_capture_reg
  import bit_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  input  mode_t            mode,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] captured,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  // One extra bit so the range check also works when WIDTH is a power of two.
  localparam logic [SEL_W:0] WIDTH_L = (SEL_W + 1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             err_q, err_d;
  logic             accept;
  logic             sel_ok;

  assign accept = load_valid && (state_q == COLLECT);
  assign sel_ok = ({1'b0, sel} < WIDTH_L);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cap_d   = cap_q;
    err_d   = 1'b0;

    if (clear) begin
      state_d = COLLECT;
      out_d   = '0;
      cap_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            case (mode)
              MODE_BIT: begin
                if (sel_ok) begin
                  out_d[sel] = in[sel];
                  cap_d[sel] = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              MODE_ALL: begin
                out_d = in;
                cap_d = '1;
              end
              MODE_SHIFT: begin
                out_d = {out_q[WIDTH-2:0], in[0]};
                cap_d = {cap_q[WIDTH-2:0], 1'b1};
              end
              default: err_d = 1'b1;
            endcase
            if (&cap_d) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Data stays visible after handoff; only the mask restarts.
          if (out_ready) begin
            state_d = COLLECT;
            cap_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      out_q   <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end

  assign load_ready = (state_q == COLLECT);
  assign out_valid  = (state_q == HOLD);
  assign out        = out_q;
  assign captured   = cap_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bit_capture_reg.sv
// Directed bench for bit_capture_reg: an 8-bit instance plus a 6-bit instance for range errors.
module tb_bit_capture_reg;
  import bit_capture_pkg::*;

  logic clk;
  logic rst_n;

  logic [7:0] in8, out8, cap8;
  logic [2:0] sel8;
  mode_t      mode8;
  logic       lv8, lr8, clr8, ov8, or8, err8;

  logic [5:0] in6, out6, cap6;
  logic [2:0] sel6;
  mode_t      mode6;
  logic       lv6, lr6, clr6, ov6, or6, err6;

  int n_checks;
  int n_fail;

  bit_capture_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .mode(mode8),
    .load_valid(lv8), .load_ready(lr8), .clear(clr8), .out(out8),
    .captured(cap8), .out_valid(ov8), .out_ready(or8), .err(err8)
  );

  bit_capture_reg #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in(in6), .sel(sel6), .mode(mode6),
    .load_valid(lv6), .load_ready(lr6), .clear(clr6), .out(out6),
    .captured(cap6), .out_valid(ov6), .out_ready(or6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in8 = '0; sel8 = '0; mode8 = MODE_BIT; lv8 = 0; clr8 = 0; or8 = 0;
    in6 = '0; sel6 = '0; mode6 = MODE_BIT; lv6 = 0; clr6 = 0; or6 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out8, cap8, lr8, ov8, err8} !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8: out=%h cap=%h lr=%b ov=%b err=%b, want 00 00 1 0 0", out8, cap8, lr8, ov8, err8);
    end
    n_checks++;
    if ({out6, cap6, lr6, ov6, err6} !== {6'h00, 6'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset6: out=%h cap=%h lr=%b ov=%b err=%b, want 00 00 1 0 0", out6, cap6, lr6, ov6, err6);
    end
    $display("reset done");
  endtask

  task automatic test_mode_bit();
    logic [7:0] exp_cap;
    mode8 = MODE_BIT; in8 = 8'hA5; lv8 = 1;
    for (int i = 0; i < 8; i++) begin
      sel8 = 3'(i);
      tick();
      exp_cap = 8'((16'h1 << (i + 1)) - 1);
      n_checks++;
      if (cap8 !== exp_cap) begin
        n_fail++;
        $display("FAIL bit_cap[%0d]: got %h want %h", i, cap8, exp_cap);
      end
      n_checks++;
      if (ov8 !== (i == 7)) begin
        n_fail++;
        $display("FAIL bit_valid[%0d]: got %b want %b", i, ov8, (i == 7));
      end
      $display("bit sel=%0d cap=%h out=%h ov=%b", i, cap8, out8, ov8);
    end
    lv8 = 0;
    n_checks++;
    if (out8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL bit_out: got %h want a5", out8);
    end
    or8 = 1;
    tick();
    or8 = 0;
    n_checks++;
    if ({lr8, ov8, cap8, out8} !== {1'b1, 1'b0, 8'h00, 8'hA5}) begin
      n_fail++;
      $display("FAIL bit_release: lr=%b ov=%b cap=%h out=%h, want 1 0 00 a5", lr8, ov8, cap8, out8);
    end
  endtask

  task automatic test_hold();
    mode8 = MODE_ALL; in8 = 8'h3C; lv8 = 1;
    tick();
    in8 = 8'hFF;
    n_checks++;
    if ({out8, cap8, ov8, lr8} !== {8'h3C, 8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL all_cap: out=%h cap=%h ov=%b lr=%b, want 3c ff 1 0", out8, cap8, ov8, lr8);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out8, ov8, lr8} !== {8'h3C, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: out=%h ov=%b lr=%b, want 3c 1 0", i, out8, ov8, lr8);
      end
      $display("hold cycle %0d out=%h ov=%b", i, out8, ov8);
    end
    // load_valid still high during release: must not be accepted.
    or8 = 1;
    tick();
    or8 = 0; lv8 = 0;
    n_checks++;
    if ({lr8, ov8, cap8, out8} !== {1'b1, 1'b0, 8'h00, 8'h3C}) begin
      n_fail++;
      $display("FAIL all_release: lr=%b ov=%b cap=%h out=%h, want 1 0 00 3c", lr8, ov8, cap8, out8);
    end
  endtask

  task automatic test_shift();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    mode8 = MODE_SHIFT; lv8 = 1;
    for (int i = 0; i < 8; i++) begin
      in8 = {7'h00, bits[7 - i]};
      tick();
      n_checks++;
      if (ov8 !== (i == 7)) begin
        n_fail++;
        $display("FAIL shift_valid[%0d]: got %b want %b", i, ov8, (i == 7));
      end
      $display("shift bit=%b out=%h cap=%h", bits[7 - i], out8, cap8);
    end
    lv8 = 0;
    n_checks++;
    if ({out8, cap8} !== {8'hB2, 8'hFF}) begin
      n_fail++;
      $display("FAIL shift_out: out=%h cap=%h, want b2 ff", out8, cap8);
    end
    or8 = 1;
    tick();
    or8 = 0;
  endtask

  task automatic test_bit_overwrite();
    mode8 = MODE_BIT; sel8 = 3'd2; lv8 = 1; in8 = 8'h04;
    tick();
    in8 = 8'h00;
    tick();
    lv8 = 0;
    n_checks++;
    if ({out8[2], cap8, ov8} !== {1'b0, 8'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL overwrite: out2=%b cap=%h ov=%b, want 0 04 0", out8[2], cap8, ov8);
    end
    $display("overwrite out=%h cap=%h", out8, cap8);
  endtask

  task automatic test_illegal();
    clr8 = 1;
    tick();
    clr8 = 0;
    mode8 = MODE_BIT; sel8 = 3'd1; in8 = 8'h02; lv8 = 1;
    tick();
    mode8 = MODE_RSVD; in8 = 8'hFF;
    tick();
    lv8 = 0;
    n_checks++;
    if ({err8, out8, cap8} !== {1'b1, 8'h02, 8'h02}) begin
      n_fail++;
      $display("FAIL rsvd: err=%b out=%h cap=%h, want 1 02 02", err8, out8, cap8);
    end
    tick();
    n_checks++;
    if (err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd_pulse: err=%b want 0", err8);
    end
    mode6 = MODE_BIT; sel6 = 3'd5; in6 = 6'h20; lv6 = 1;
    tick();
    n_checks++;
    if ({cap6, out6, err6} !== {6'h20, 6'h20, 1'b0}) begin
      n_fail++;
      $display("FAIL w6_legal: cap=%h out=%h err=%b, want 20 20 0", cap6, out6, err6);
    end
    sel6 = 3'd7; in6 = 6'h3F;
    tick();
    lv6 = 0;
    n_checks++;
    if ({err6, cap6, out6} !== {1'b1, 6'h20, 6'h20}) begin
      n_fail++;
      $display("FAIL w6_range: err=%b cap=%h out=%h, want 1 20 20", err6, cap6, out6);
    end
    tick();
    n_checks++;
    if (err6 !== 1'b0) begin
      n_fail++;
      $display("FAIL w6_pulse: err=%b want 0", err6);
    end
    $display("illegal requests checked");
  endtask

  task automatic test_clear();
    mode8 = MODE_BIT; in8 = 8'hFF; lv8 = 1;
    for (int i = 0; i < 5; i++) begin
      sel8 = 3'(i);
      tick();
    end
    n_checks++;
    if (cap8 !== 8'h1F) begin
      n_fail++;
      $display("FAIL pre_clear: cap=%h want 1f", cap8);
    end
    sel8 = 3'd5; clr8 = 1;
    tick();
    clr8 = 0; lv8 = 0;
    n_checks++;
    if ({out8, cap8, lr8, ov8} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clear: out=%h cap=%h lr=%b ov=%b, want 00 00 1 0", out8, cap8, lr8, ov8);
    end
    $display("clear out=%h cap=%h", out8, cap8);
  endtask

  task automatic test_async_reset();
    mode8 = MODE_ALL; in8 = 8'h5A; lv8 = 1;
    tick();
    lv8 = 0;
    n_checks++;
    if (ov8 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: ov=%b want 1", ov8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov8, lr8, out8, cap8} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL async_rst: ov=%b lr=%b out=%h cap=%h, want 0 1 00 00", ov8, lr8, out8, cap8);
    end
    #1;
    rst_n = 1'b1;
    tick();
    $display("async reset ov=%b out=%h", ov8, out8);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mode_bit();
    test_hold();
    test_shift();
    test_bit_overwrite();
    test_illegal();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_capture_reg.md
# bit_capture_reg

Parametrised bit-slice capture register that assembles an output word from individually selected input bits, whole-word loads, or a serial shift stream. It tracks which bits have been written and presents the completed word on a valid/ready handshake, holding it until the consumer accepts. It sits between a bit-producing front end and any word-wide consumer in the datapath, replacing ad-hoc per-bit latches with clocked, reset-defined storage.

## Interface
- WIDTH, 8, output word width (≥2)
- SEL_W, $clog2(WIDTH), width of the bit-select field
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  source word
- sel  input  SEL_W  bit index for MODE_BIT
- mode  input  2  capture mode (mode_t)
- load_valid  input  1  capture request
- load_ready  output  1  block can accept a capture
- clear  input  1  synchronous abort/flush
- out  output  WIDTH  assembled word (registered)
- captured  output  WIDTH  per-bit written mask (registered)
- out_valid  output  1  word complete, held until accepted
- out_ready  input  1  consumer accepts word
- err  output  1  one-cycle pulse on illegal accepted request

One clock; reset is asynchronous and active-low.

## Operation
- States: COLLECT, HOLD. load_ready = (state == COLLECT); out_valid = (state == HOLD).
- Accept = load_valid & load_ready. Non-accepted requests have no effect.
- MODE_BIT (2'b00): out[sel] <= in[sel]; captured[sel] <= 1. Re-capturing a set bit overwrites data, mask unchanged.
- MODE_ALL (2'b01): out <= in; captured <= all ones.
- MODE_SHIFT (2'b10): out <= {out[WIDTH-2:0], in[0]}; captured <= {captured[WIDTH-2:0], 1'b1}.
- Mode 2'b11, or MODE_BIT with sel ≥ WIDTH: no state change, err pulses next cycle.
- If the post-accept mask is all ones, state → HOLD on the same edge.
- HOLD: out and captured frozen. out_ready → COLLECT next edge, captured cleared, out retained (not zeroed).
- clear (highest priority, any state): out = 0, captured = 0, state = COLLECT, err = 0. clear with an accept in the same cycle: clear wins, capture discarded.
- out_ready in COLLECT is ignored.

## Timing
- Reset values: out = 0, captured = 0, state = COLLECT (load_ready = 1, out_valid = 0), err = 0.
- Capture latency 1 cycle: accept sampled at edge N, out/captured updated after edge N.
- Completing capture at edge N → out_valid high after edge N; earliest release at edge N+1 with out_ready → load_ready high after N+1.
- Minimum cycle per word: MODE_ALL 2 cycles (capture + handoff); MODE_SHIFT WIDTH+1 cycles.
- err is a registered one-cycle pulse, asserted after the edge that accepted the illegal request.
- rst_n asserted mid-word or in HOLD: all state returns to reset values immediately, independent of clk; pending word lost.

## Structure
- Package bit_capture_pkg: typedef enum logic [1:0] mode_t {MODE_BIT, MODE_ALL, MODE_SHIFT, MODE_RSVD}; typedef enum logic state_t {COLLECT, HOLD}.
- Single module; no sub-module is natural. Mask, data and FSM update in one always_ff with async reset; next-value selection in always_comb with full defaults (no inferred latches).

## Test plan
- Reset then MODE_BIT, in = 8'hA5, sel = 0..7 one per cycle with load_valid → out = 8'hA5 and out_valid after 8th edge; captured steps 01,03,…,FF.
- MODE_ALL in = 8'h3C, out_ready held low 5 cycles → out_valid stays 1, load_ready 0, further load_valid ignored; out_ready → load_ready 1 next cycle, captured = 0, out still 8'h3C.
- MODE_SHIFT in[0] sequence 1,0,1,1,0,0,1,0 → out = 8'hB2, out_valid after 8th accept.
- MODE_BIT sel = 2 twice with in[2] = 1 then 0 → out[2] = 0, captured = 8'h04, no out_valid.
- mode = 2'b11 accepted → err pulses 1 cycle, out/captured unchanged; WIDTH = 6 instance with sel = 7 → same.
- clear asserted with load_valid in the same cycle after 5 bits captured → out = 0, captured = 0, COLLECT; rst_n pulsed low in HOLD between edges → out_valid drops without a clock edge.
